// File: rtl/reset_tick_generator.sv
// Board reset sequencer: waits for PLL lock, holds reset_out, then runs clock-enable dividers.
// Optional RESET_TICK_LOCK_LOSS_RESTART_EN: lock loss in RUN restarts the whole sequence.
module reset_tick_generator #(
  parameter int unsigned              RESET_CYCLES = 65536,
  parameter int unsigned              N_CH         = 2,
  parameter int unsigned              DIV_W        = 16,
  parameter logic [N_CH*DIV_W-1:0]    DIV_RATIOS   = {16'd12, 16'd1},
  parameter int unsigned              SYNC_STAGES  = 2,
  parameter int unsigned              HB_BIT       = 23
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            lock_in,
  output logic            reset_out,
  output logic            resetn_out,
  output logic [N_CH-1:0] tick_out,
  output logic [N_CH-1:0] div_out,
  output logic            heartbeat_out,
  output logic [1:0]      state_out
);

  localparam int unsigned HoldW = $clog2(RESET_CYCLES) + 1;
  localparam int unsigned HbW   = HB_BIT + 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StHold     = 2'd1,
    StRun      = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    lock_s;
  logic [HoldW-1:0]        hold_cnt_q, hold_cnt_d;
  logic [HbW-1:0]          hb_cnt_q;
  logic                    reset_q, resetn_q;
  logic                    run_d, run_stay;
  logic [DIV_W-1:0]        ratio   [N_CH];
  logic [DIV_W-1:0]        cnt_q   [N_CH];
  logic [DIV_W-1:0]        cnt_d   [N_CH];
  logic [N_CH-1:0]         wrap;
  logic [N_CH-1:0]         tick_q, tick_d;
  logic [N_CH-1:0]         div_q, div_d;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= StWaitLock;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a lock drop beats the hold-complete transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      StWaitLock: if (lock_s) state_d = StHold;
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
`ifdef RESET_TICK_LOCK_LOSS_RESTART_EN
        if (!lock_s) state_d = StWaitLock;
`else
        state_d = StRun;
`endif
      end
      default: state_d = StWaitLock;
    endcase
  end

  always_comb begin
    hold_cnt_d = '0;
    if (state_q == StHold && state_d == StHold) begin
      hold_cnt_d = hold_cnt_q + HoldW'(1);
    end
  end

  // Output logic: dividers advance only while staying in RUN, so they start phase-aligned
  always_comb begin
    run_d    = (state_d == StRun);
    run_stay = (state_q == StRun) && run_d;
    for (int i = 0; i < N_CH; i++) begin
      ratio[i] = DIV_RATIOS[i*DIV_W +: DIV_W];
      cnt_d[i] = '0;
    end
    wrap   = '0;
    tick_d = '0;
    div_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (run_stay && ratio[i] != '0) begin
        wrap[i]   = (cnt_q[i] == ratio[i] - DIV_W'(1));
        cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + DIV_W'(1);
        tick_d[i] = wrap[i];
        div_d[i]  = div_q[i] ^ wrap[i];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      hold_cnt_q <= '0;
      hb_cnt_q   <= '0;
      reset_q    <= 1'b1;
      resetn_q   <= 1'b0;
      tick_q     <= '0;
      div_q      <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hb_cnt_q   <= hb_cnt_q + HbW'(1);
      reset_q    <= !run_d;
      resetn_q   <= run_d;
      tick_q     <= tick_d;
      div_q      <= div_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign reset_out     = reset_q;
  assign resetn_out    = resetn_q;
  assign tick_out      = tick_q;
  assign div_out       = div_q;
  assign heartbeat_out = hb_cnt_q[HB_BIT];
  assign state_out     = state_q;

endmodule
